r2sdf_stage: RTL and testbench

- One radix-2 single-path delay-feedback (R2SDF) butterfly stage of the streaming FFT.
- Sits directly upstream of the twiddle factor multiplier. It takes one complex sample per enabled cycle and emits butterfly sums and differences in stream order.
- With each output it emits the twiddle index that the downstream sin/cos ROM uses to drive the multiplier.

---
 rtl/r2sdf_stage.sv | 115 +++++++++++
 tb/tb_r2sdf_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback (R2SDF) butterfly stage.
//
// Accepts one complex sample per enabled cycle. During the FILL half of a
// frame, samples are parked in a DEPTH-entry delay line and the previous
// frame's differences are emitted with their twiddle index. During the BFLY
// half, the parked sample is combined with the new one: the sum is emitted
// and the difference is stored for the next FILL half.
//
// Optional build macro:
//   R2SDF_SCALE_EN  defined   -> results are arithmetically shifted right by 1
//                                (1/2 scaling per stage, no overflow)
//                   undefined -> low DATA_WIDTH bits are kept (wrap-around)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   en       input sample valid; the stage advances only when en=1
//   sync     frame start (qualified by en); forces the sample to index 0
//   data_re  signed input real part
//   data_im  signed input imaginary part
//   out_re   signed output real part (registered)
//   out_im   signed output imaginary part (registered)
//   out_val  1-cycle pulse per emitted output
//   tw_idx   twiddle index for the sample on out_*; 0 for sums
module r2sdf_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync,
  input  logic [DATA_WIDTH-1:0] data_re,
  input  logic [DATA_WIDTH-1:0] data_im,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_val,
  output logic [ADDR_WIDTH-1:0] tw_idx
);

  localparam int W = DATA_WIDTH;

  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_cur;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  bfly;
  logic                  primed_q;

  logic [W-1:0] dl_re_q [DEPTH];
  logic [W-1:0] dl_im_q [DEPTH];

  logic [W-1:0] old_re, old_im;
  logic [W:0]   sum_re, sum_im, diff_re, diff_im;

  // Bring a W+1 bit result back to W bits.
  function automatic logic [W-1:0] reduce(input logic [W:0] x);
`ifdef R2SDF_SCALE_EN
    return x[W:1];
`else
    return x[W-1:0];
`endif
  endfunction

  always_comb begin
    // sync restarts the frame on this very sample
    cnt_cur = sync ? '0 : cnt_q;
    ptr     = cnt_cur[ADDR_WIDTH-1:0];
    bfly    = cnt_cur[ADDR_WIDTH];
    old_re  = dl_re_q[ptr];
    old_im  = dl_im_q[ptr];
    sum_re  = {old_re[W-1], old_re} + {data_re[W-1], data_re};
    sum_im  = {old_im[W-1], old_im} + {data_im[W-1], data_im};
    diff_re = {old_re[W-1], old_re} - {data_re[W-1], data_re};
    diff_im = {old_im[W-1], old_im} - {data_im[W-1], data_im};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      out_re   <= '0;
      out_im   <= '0;
      out_val  <= 1'b0;
      tw_idx   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dl_re_q[i] <= '0;
        dl_im_q[i] <= '0;
      end
    end else if (en) begin
      // Counter width is ADDR_WIDTH+1, so it wraps at 2*DEPTH on its own.
      cnt_q <= cnt_cur + {{ADDR_WIDTH{1'b0}}, 1'b1};
      if (bfly) begin
        out_re       <= reduce(sum_re);
        out_im       <= reduce(sum_im);
        tw_idx       <= '0;
        out_val      <= 1'b1;
        dl_re_q[ptr] <= reduce(diff_re);
        dl_im_q[ptr] <= reduce(diff_im);
        primed_q     <= 1'b1;
      end else begin
        // Drain the previous frame's difference while parking the new sample.
        out_re       <= old_re;
        out_im       <= old_im;
        tw_idx       <= ptr;
        out_val      <= primed_q;
        dl_re_q[ptr] <= data_re;
        dl_im_q[ptr] <= data_im;
      end
    end else begin
      out_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Bench for r2sdf_stage (DATA_WIDTH=16, DEPTH=2): directed cases with literal
// expectations plus a randomized run, all checked every cycle against a
// frame-level behavioural model.
module tb_r2sdf_stage;

  localparam int DW = 16;
  localparam int D  = 2;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          sync = 1'b0;
  logic [DW-1:0] data_re = '0;
  logic [DW-1:0] data_im = '0;
  logic [DW-1:0] out_re, out_im;
  logic          out_val;
  logic [AW-1:0] tw_idx;

  int errors = 0;
  int checks = 0;

  r2sdf_stage #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .data_re (data_re),
    .data_im (data_im),
    .out_re  (out_re),
    .out_im  (out_im),
    .out_val (out_val),
    .tw_idx  (tw_idx)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_re [D];
  int m_im [D];
  int m_pos;        // position within frame, 0 .. 2*D-1
  bit m_primed;
  int exp_re, exp_im, exp_tw;
  bit exp_val;

  function automatic int red(input int x);
    int y;
`ifdef R2SDF_SCALE_EN
    y = x >>> 1;
`else
    y = x;
`endif
    return int'($signed(y[15:0]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_re[i] = 0;
      m_im[i] = 0;
    end
    m_pos = 0; m_primed = 0;
    exp_re = 0; exp_im = 0; exp_tw = 0; exp_val = 0;
  endtask

  task automatic model_step(input bit e, input bit s, input int re, input int im);
    int p, dre, dim;
    if (!e) begin
      exp_val = 0;
      return;
    end
    if (s) m_pos = 0;
    p = m_pos % D;
    dre = m_re[p];
    dim = m_im[p];
    if (m_pos < D) begin
      exp_re = dre; exp_im = dim; exp_tw = p; exp_val = m_primed;
      m_re[p] = re; m_im[p] = im;
    end else begin
      exp_re = red(dre + re); exp_im = red(dim + im); exp_tw = 0; exp_val = 1;
      m_re[p] = red(dre - re); m_im[p] = red(dim - im);
      m_primed = 1;
    end
    m_pos = (m_pos + 1) % (2 * D);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_val", int'(out_val), int'(exp_val));
    chk("out_re", int'($signed(out_re)), exp_re);
    chk("out_im", int'($signed(out_im)), exp_im);
    chk("tw_idx", int'(tw_idx), exp_tw);
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit e, input bit s, input int re, input int im);
    int sre, sim;
    @(negedge clk);
    en = e; sync = s;
    data_re = re[15:0]; data_im = im[15:0];
    sre = int'($signed(data_re));
    sim = int'($signed(data_im));
    @(posedge clk);
    model_step(e, s, sre, sim);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; sync = 0;
    #2 rst = 0;
    model_reset();
    #1;
    chk("rst_out_re", int'($signed(out_re)), 0);
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_tw_idx", int'(tw_idx), 0);
    @(negedge clk);
    #2 rst = 1;
  endtask

  task automatic gaps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom, $urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1;

    // Case 1: 1,2,3,4 then 5,6 then 7,8
    step(1, 0, 1, 0); chk("c1_val0", int'(out_val), 0);
    step(1, 0, 2, 0); chk("c1_val1", int'(out_val), 0);
    step(1, 0, 3, 0); chk("c1_sum0", int'($signed(out_re)), 4);
    chk("c1_val2", int'(out_val), 1);
    step(1, 0, 4, 0); chk("c1_sum1", int'($signed(out_re)), 6);
    chk("c1_tw1", int'(tw_idx), 0);
    step(1, 0, 5, 0); chk("c1_diff0", int'($signed(out_re)), -2);
    chk("c1_dtw0", int'(tw_idx), 0);
    step(1, 0, 6, 0); chk("c1_diff1", int'($signed(out_re)), -2);
    chk("c1_dtw1", int'(tw_idx), 1);
    chk("c1_dval1", int'(out_val), 1);
    step(1, 0, 7, 0); chk("c1_sum2", int'($signed(out_re)), 12);
    step(1, 0, 8, 0); chk("c1_sum3", int'($signed(out_re)), 14);

    // Case 2: same frame with 3-cycle gaps, after reset
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, i, 0);
      gaps(3);
      chk("c2_hold_val", int'(out_val), 0);
      if (i == 3) chk("c2_hold_sum0", int'($signed(out_re)), 4);
      if (i == 4) chk("c2_hold_sum1", int'($signed(out_re)), 6);
    end

    // Case 3: overflow on the sum
    do_reset();
    step(1, 0, 32'h7FFF, 0);
    step(1, 0, 0, 0);
    step(1, 0, 32'h7FFF, 0);
`ifdef R2SDF_SCALE_EN
    chk("c3_sum", int'($signed(out_re)), 32767);
`else
    chk("c3_sum", int'($signed(out_re)), -2);
`endif
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); chk("c3_diff", int'($signed(out_re)), 0);

    // Case 4: sync on the second sample of a frame
    do_reset();
    step(1, 0, 10, 0);
    step(1, 1, 20, 0); chk("c4_tw0", int'(tw_idx), 0);
    step(1, 0, 30, 0); chk("c4_tw1", int'(tw_idx), 1);
    chk("c4_val", int'(out_val), 0);
    step(1, 0, 40, 0); chk("c4_sum0", int'($signed(out_re)), 60);
    step(1, 0, 50, 0); chk("c4_sum1", int'($signed(out_re)), 80);
    step(1, 0, 0, 0);  chk("c4_diff0", int'($signed(out_re)), -20);

    // Case 5: reset mid-BFLY, then first case again
    do_reset();
    step(1, 0, 1, 0); step(1, 0, 2, 0); step(1, 0, 3, 0);
    do_reset();
    step(1, 0, 1, 0); step(1, 0, 2, 0);
    chk("c5_val1", int'(out_val), 0);
    step(1, 0, 3, 0); chk("c5_sum0", int'($signed(out_re)), 4);
    step(1, 0, 4, 0); chk("c5_sum1", int'($signed(out_re)), 6);

    // Randomized run, checked cycle by cycle by the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           int'($urandom & 32'hFFFF), int'($urandom & 32'hFFFF));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
